// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory arbiter.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-input round-robin pick; one-hot winner, zero when not advancing.
// Revision : 1.0
// ============================================================================
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       advance,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // On a tie the port that did not win last time goes first
                2'b11:   gnt = (last_gnt == PORT_DMA) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin sequencer sharing one single-port data memory
//            between the CPU load/store unit and the DMA/debug loader.
// Revision : 1.0
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_gnt;
    logic              r_port;
    logic              r_we;
    logic              r_first;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        w_win;
    logic              w_arb_en;
    logic              w_misal;
    logic              w_read_issue;

    assign w_arb_en     = (r_state == IDLE) || (r_state == RESP);
    assign w_misal      = (r_addr[1:0] != 2'b00);
    assign w_read_issue = (r_state == ISSUE) && !r_we && !w_misal;

    rr_arbiter2 u_rr (
        .req      ({m1_req, m0_req}),
        .last_gnt (r_last_gnt),
        .advance  (w_arb_en),
        .gnt      (w_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, RESP: w_state_next = (w_win != 2'b00) ? ISSUE : IDLE;
            ISSUE: begin
                if (r_we || w_misal) begin
                    w_state_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = RESP;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Command latch, read-latency down-counter and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= PORT_DMA;
            r_port     <= PORT_CPU;
            r_we       <= 1'b0;
            r_first    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            r_first <= 1'b0;
            if (w_win != 2'b00) begin
                r_port     <= w_win[1];
                r_last_gnt <= w_win[1];
                r_first    <= 1'b1;
                r_we       <= w_win[1] ? m1_we    : m0_we;
                r_addr     <= w_win[1] ? m1_addr  : m0_addr;
                r_wdata    <= w_win[1] ? m1_wdata : m0_wdata;
                r_cnt      <= CNT_W'(MEM_LAT - 1);
            end else if (w_read_issue) begin
                if (r_cnt == '0) begin
                    r_rdata <= mem_rdata;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        m0_gnt    = 1'b0;
        m0_err    = 1'b0;
        m0_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_gnt    = 1'b0;
        m1_err    = 1'b0;
        m1_rvalid = 1'b0;
        m1_rdata  = '0;
        busy      = (r_state != IDLE);
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_read  = w_read_issue;
        mem_write = (r_state == ISSUE) && r_first && r_we && !w_misal;
        if ((r_state == ISSUE) && r_first) begin
            if (r_port == PORT_CPU) begin
                m0_gnt = 1'b1;
                m0_err = w_misal;
            end else begin
                m1_gnt = 1'b1;
                m1_err = w_misal;
            end
        end
        if (r_state == RESP) begin
            if (r_port == PORT_CPU) begin
                m0_rvalid = 1'b1;
                m0_rdata  = r_rdata;
            end else begin
                m1_rvalid = 1'b1;
                m1_rdata  = r_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Two arbiter instances (MEM_LAT 1 and 3) against a cycle-scheduled
//            transaction model and per-instance memory models.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int NC = 2048;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
    } cmd_t;

    typedef struct {
        bit [1:0]  gnt;
        bit [1:0]  err;
        bit [1:0]  rv;
        bit        mr;
        bit        mw;
        bit        busy;
        bit        setaddr;
        bit [31:0] rdata;
        bit [31:0] addr;
        bit [31:0] wdata;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req   [4];
    logic        i_we    [4];
    logic [31:0] i_addr  [4];
    logic [31:0] i_wdata [4];
    logic        o_gnt   [4];
    logic        o_err   [4];
    logic        o_rv    [4];
    logic [31:0] o_rdata [4];
    logic [31:0] o_maddr [2];
    logic [31:0] o_mwdata[2];
    logic [31:0] m_rdata [2];
    logic        o_mw    [2];
    logic        o_mr    [2];
    logic        o_busy  [2];
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    assign m_rdata[0] = mem0[o_maddr[0][9:2]];
    assign m_rdata[1] = mem1[o_maddr[1][9:2]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(i_req[0]), .m0_we(i_we[0]), .m0_addr(i_addr[0]), .m0_wdata(i_wdata[0]),
        .m0_gnt(o_gnt[0]), .m0_rvalid(o_rv[0]), .m0_rdata(o_rdata[0]), .m0_err(o_err[0]),
        .m1_req(i_req[1]), .m1_we(i_we[1]), .m1_addr(i_addr[1]), .m1_wdata(i_wdata[1]),
        .m1_gnt(o_gnt[1]), .m1_rvalid(o_rv[1]), .m1_rdata(o_rdata[1]), .m1_err(o_err[1]),
        .mem_addr(o_maddr[0]), .mem_wdata(o_mwdata[0]), .mem_write(o_mw[0]),
        .mem_read(o_mr[0]), .mem_rdata(m_rdata[0]), .busy(o_busy[0])
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(i_req[2]), .m0_we(i_we[2]), .m0_addr(i_addr[2]), .m0_wdata(i_wdata[2]),
        .m0_gnt(o_gnt[2]), .m0_rvalid(o_rv[2]), .m0_rdata(o_rdata[2]), .m0_err(o_err[2]),
        .m1_req(i_req[3]), .m1_we(i_we[3]), .m1_addr(i_addr[3]), .m1_wdata(i_wdata[3]),
        .m1_gnt(o_gnt[3]), .m1_rvalid(o_rv[3]), .m1_rdata(o_rdata[3]), .m1_err(o_err[3]),
        .mem_addr(o_maddr[1]), .mem_wdata(o_mwdata[1]), .mem_write(o_mw[1]),
        .mem_read(o_mr[1]), .mem_rdata(m_rdata[1]), .busy(o_busy[1])
    );

    exp_t      ex [2][NC];
    exp_t      ex_zero;
    cmd_t      rq [4][$];
    bit        present [4];
    bit [31:0] shadow [2][256];
    int        k, n_chk, n_fail;
    int        next_arb [2];
    bit        last [2];
    bit [31:0] hold_a [2];
    bit [31:0] hold_d [2];
    bit [31:0] last_rd [4];
    int        gnt_cyc [2];
    int        rv_cyc [2];
    int        err_cyc [2];
    int        mr_cnt [2];
    int        glog_port [$];
    int        glog_cyc [$];

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic cmd_t mk_cmd(input bit we, input bit [31:0] addr, input bit [31:0] wdata);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t     c;
        bit [7:0] w;
        w       = 8'($urandom_range(0, 255));
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = {22'd0, w, 2'b00};
        if ($urandom_range(0, 7) == 0) c.addr[1:0] = 2'($urandom_range(1, 3));
        c.wdata = $urandom;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    task automatic check_cycle();
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            e = ex[i][k];
            if (e.setaddr) begin
                hold_a[i] = e.addr;
                hold_d[i] = e.wdata;
            end
            for (int p = 0; p < 2; p++) begin
                int x;
                x = i * 2 + p;
                chk($sformatf("u%0d_m%0d_gnt", i, p), 32'(o_gnt[x]), 32'(e.gnt[p]));
                chk($sformatf("u%0d_m%0d_err", i, p), 32'(o_err[x]), 32'(e.err[p]));
                chk($sformatf("u%0d_m%0d_rvalid", i, p), 32'(o_rv[x]), 32'(e.rv[p]));
                chk($sformatf("u%0d_m%0d_rdata", i, p), o_rdata[x], e.rv[p] ? e.rdata : 32'd0);
                if (o_gnt[x] === 1'b1) begin
                    gnt_cyc[i] = k;
                    if (i == 0) begin
                        glog_port.push_back(p);
                        glog_cyc.push_back(k);
                    end
                end
                if (o_err[x] === 1'b1) err_cyc[i] = k;
                if (o_rv[x] === 1'b1) begin
                    rv_cyc[i]  = k;
                    last_rd[x] = o_rdata[x];
                end
            end
            chk($sformatf("u%0d_mem_read", i), 32'(o_mr[i]), 32'(e.mr));
            chk($sformatf("u%0d_mem_write", i), 32'(o_mw[i]), 32'(e.mw));
            chk($sformatf("u%0d_busy", i), 32'(o_busy[i]), 32'(e.busy));
            chk($sformatf("u%0d_mem_addr", i), o_maddr[i], hold_a[i]);
            chk($sformatf("u%0d_mem_wdata", i), o_mwdata[i], hold_d[i]);
            if (o_mr[i] === 1'b1) mr_cnt[i]++;
        end
    endtask

    task automatic mem_update();
        if (o_mw[0] === 1'b1) mem0[o_maddr[0][9:2]] = o_mwdata[0];
        if (o_mw[1] === 1'b1) mem1[o_maddr[1][9:2]] = o_mwdata[1];
    endtask

    task automatic drive();
        for (int x = 0; x < 4; x++) begin
            if (rq[x].size() > 0 && present[x]) begin
                i_req[x]   = 1'b1;
                i_we[x]    = rq[x][0].we;
                i_addr[x]  = rq[x][0].addr;
                i_wdata[x] = rq[x][0].wdata;
            end else begin
                i_req[x] = 1'b0;
            end
        end
    endtask

    // Schedule every output event of a granted transaction by absolute cycle
    task automatic decide();
        for (int i = 0; i < 2; i++) begin
            if (rst_n && k >= next_arb[i] && (i_req[2*i] || i_req[2*i+1])) begin
                int   w, t;
                bit   mis;
                cmd_t c;
                if (i_req[2*i] && i_req[2*i+1]) w = last[i] ? 0 : 1;
                else                            w = i_req[2*i+1] ? 1 : 0;
                last[i] = w[0];
                c   = rq[2*i+w].pop_front();
                t   = k + 1;
                mis = (c.addr[1:0] != 2'b00);
                ex[i][t].gnt[w]  = 1'b1;
                ex[i][t].err[w]  = mis;
                ex[i][t].setaddr = 1'b1;
                ex[i][t].addr    = c.addr;
                ex[i][t].wdata   = c.wdata;
                if (mis || c.we) begin
                    ex[i][t].busy = 1'b1;
                    if (!mis) begin
                        ex[i][t].mw = 1'b1;
                        shadow[i][c.addr[9:2]] = c.wdata;
                    end
                    next_arb[i] = k + 2;
                end else begin
                    for (int j = 0; j < lat(i); j++) begin
                        ex[i][t+j].mr   = 1'b1;
                        ex[i][t+j].busy = 1'b1;
                    end
                    ex[i][t+lat(i)].rv[w] = 1'b1;
                    ex[i][t+lat(i)].rdata = shadow[i][c.addr[9:2]];
                    ex[i][t+lat(i)].busy  = 1'b1;
                    next_arb[i] = t + lat(i);
                end
            end
        end
    endtask

    task automatic model_reset(input int from);
        for (int i = 0; i < 2; i++) begin
            for (int c = from; c < NC; c++) ex[i][c] = ex_zero;
            next_arb[i] = 0;
            last[i]     = 1'b1;
            hold_a[i]   = '0;
            hold_d[i]   = '0;
        end
        for (int x = 0; x < 4; x++) rq[x].delete();
    endtask

    task automatic run(input int n);
        for (int s = 0; s < n; s++) begin
            check_cycle();
            mem_update();
            drive();
            decide();
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()) != 0 ||
                k < next_arb[0] + 1 || k < next_arb[1] + 1) && b < 300) begin
            run(1);
            b++;
        end
        n_chk++;
        assert (b < 300) else begin
            n_fail++;
            $error("FAIL drain_timeout observed=%0d cycles expected below 300", b);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; k = 0;
        for (int x = 0; x < 4; x++) begin
            i_req[x] = 1'b0; i_we[x] = 1'b0; i_addr[x] = '0; i_wdata[x] = '0;
            present[x] = 1'b1; last_rd[x] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            gnt_cyc[i] = -1; rv_cyc[i] = -1; err_cyc[i] = -1; mr_cnt[i] = 0;
        end
        model_reset(0);
        for (int a = 0; a < 256; a++) begin
            mem0[a] = $urandom;
            mem1[a] = $urandom;
        end
        mem1[8'h10] = 32'h0000_1234;
        for (int a = 0; a < 256; a++) begin
            shadow[0][a] = mem0[a];
            shadow[1][a] = mem1[a];
        end

        @(posedge clk);
        #1;
        run(3);

        // Reset landing in the middle of a MEM_LAT=3 read
        rst_n = 1'b1;
        rq[2].push_back(mk_cmd(1'b0, 32'h80, 32'h0));
        run(2);
        rst_n = 1'b0;
        #1;
        chk("t1_busy_in_reset", 32'(o_busy[1]), 32'd0);
        chk("t1_mem_read_in_reset", 32'(o_mr[1]), 32'd0);
        model_reset(k);
        rv_cyc[1] = -1;
        run(3);
        rst_n = 1'b1;
        run(6);
        chk("t1_no_rvalid_after_abort", 32'(rv_cyc[1]), 32'hFFFF_FFFF);

        // m0 write then m1 read of the same word
        rq[0].push_back(mk_cmd(1'b1, 32'h10, 32'hDEAD_BEEF));
        rq[1].push_back(mk_cmd(1'b0, 32'h10, 32'h0));
        drain();
        chk("t2_m1_rdata", last_rd[1], 32'hDEAD_BEEF);
        chk("t2_rvalid_latency", 32'(rv_cyc[0] - gnt_cyc[0]), 32'd1);

        // Both ports continuously requesting
        glog_port.delete(); glog_cyc.delete();
        for (int j = 0; j < 3; j++) begin
            rq[0].push_back(mk_cmd(1'b0, 32'(j * 8), 32'h0));
            rq[1].push_back(mk_cmd(1'b0, 32'(j * 8 + 4), 32'h0));
        end
        drain();
        chk("t3_grant_count", 32'(glog_port.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            int gp;
            gp = (j < glog_port.size()) ? glog_port[j] : -1;
            chk($sformatf("t3_grant_order_%0d", j), 32'(gp), 32'(j % 2));
        end

        // Misaligned read
        mr_cnt[0] = 0; err_cyc[0] = -1;
        rq[1].push_back(mk_cmd(1'b0, 32'h22, 32'h0));
        drain();
        chk("t4_err_with_gnt", 32'(err_cyc[0]), 32'(gnt_cyc[0]));
        chk("t4_no_mem_read", 32'(mr_cnt[0]), 32'd0);

        // Three-cycle memory latency
        mr_cnt[1] = 0;
        rq[2].push_back(mk_cmd(1'b0, 32'h40, 32'h0));
        drain();
        chk("t5_mem_read_cycles", 32'(mr_cnt[1]), 32'd3);
        chk("t5_rvalid_latency", 32'(rv_cyc[1] - gnt_cyc[1]), 32'd3);
        chk("t5_rdata", last_rd[2], 32'h0000_1234);

        // Back-to-back reads at MEM_LAT=1
        glog_port.delete(); glog_cyc.delete();
        for (int j = 0; j < 4; j++) rq[0].push_back(mk_cmd(1'b0, 32'(64 + j * 4), 32'h0));
        drain();
        for (int j = 0; j < 3; j++) begin
            int d;
            d = (j + 1 < glog_cyc.size()) ? glog_cyc[j+1] - glog_cyc[j] : -1;
            chk($sformatf("t6_gnt_spacing_%0d", j), 32'(d), 32'd2);
        end

        // Random traffic with requests that come and go
        for (int n = 0; n < 400; n++) begin
            for (int x = 0; x < 4; x++) begin
                if (rq[x].size() == 0 && $urandom_range(0, 2) == 0) rq[x].push_back(rand_cmd());
                present[x] = ($urandom_range(0, 3) != 0);
            end
            run(1);
        end
        for (int x = 0; x < 4; x++) present[x] = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
